// File: rtl/hub75_linewriter_if.sv
// ---------------------------------------------------------------------------
// hub75_linewriter_if
//   Bundles the signals around the HUB75 line writer:
//     in_data, in_user, in_valid   : bit-plane pixel stream from the colormap
//                                    stage (no backpressure, in_user[0] = SOL)
//     buf_wr_addr/data/ena         : write port of the two-bank line buffer,
//                                    address is {bank, column}
//     rd_valid, rd_bank, rd_release: completed-bank handshake to the
//                                    scan/shift stage
//     err_overflow, err_short      : single-cycle error pulses
//   slave  : the line writer's view
//   master : the view of the surrounding logic (stream source + consumer)
// ---------------------------------------------------------------------------
interface hub75_linewriter_if #(
    parameter int N_CHANS    = 3,
    parameter int N_PLANES   = 8,
    parameter int N_COLS     = 64,
    parameter int LOG_N_COLS = 6,
    parameter int USER_WIDTH = 1
);
    logic [N_CHANS*N_PLANES-1:0] in_data;
    logic [USER_WIDTH-1:0]       in_user;
    logic                        in_valid;

    logic [LOG_N_COLS:0]         buf_wr_addr;
    logic [N_CHANS*N_PLANES-1:0] buf_wr_data;
    logic                        buf_wr_ena;

    logic                        rd_valid;
    logic                        rd_bank;
    logic                        rd_release;

    logic                        err_overflow;
    logic                        err_short;

    modport slave (
        input  in_data, in_user, in_valid, rd_release,
        output buf_wr_addr, buf_wr_data, buf_wr_ena,
               rd_valid, rd_bank, err_overflow, err_short
    );

    modport master (
        output in_data, in_user, in_valid, rd_release,
        input  buf_wr_addr, buf_wr_data, buf_wr_ena,
               rd_valid, rd_bank, err_overflow, err_short
    );
endinterface

// File: rtl/hub75_linewriter.sv
// ---------------------------------------------------------------------------
// hub75_linewriter
//   Writes the colormap stage's per-pixel bit-plane stream into a two-bank
//   line buffer, one display line per bank, and hands completed banks to the
//   scan/shift stage through a valid/release handshake.
//   Lines that start while the target bank is still owned by the consumer
//   are dropped whole (err_overflow); a SOL inside a line restarts that line
//   in the same bank (err_short).
//
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset, discards any partial line and
//              both banks' contents
//     bus    : hub75_linewriter_if.slave (stream in, buffer write port,
//              read handshake, error pulses)
// ---------------------------------------------------------------------------
module hub75_linewriter #(
    parameter int N_CHANS    = 3,
    parameter int N_PLANES   = 8,
    parameter int N_COLS     = 64,
    parameter int LOG_N_COLS = 6,
    parameter int USER_WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    hub75_linewriter_if.slave  bus
);
    localparam int DW = N_CHANS * N_PLANES;
    localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);
    localparam logic [LOG_N_COLS-1:0] COL_ONE  = LOG_N_COLS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                state;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [LOG_N_COLS-1:0] col;
    logic [1:0]            full;

    logic [LOG_N_COLS:0]   wr_addr_q;
    logic [DW-1:0]         wr_data_q;
    logic                  wr_ena_q;
    logic                  err_ov_q;
    logic                  err_short_q;

    logic                  sol;
    logic                  last_col;
    logic                  release_ok;
    logic [1:0]            full_clr;
    logic [1:0]            full_set;
    logic                  unused_user;

    // Only bit 0 of the sideband carries meaning.
    assign unused_user = ^bus.in_user;

    always_comb begin
        sol        = bus.in_user[0];
        last_col   = (col == LAST_COL);
        release_ok = bus.rd_release & full[rd_ptr];

        full_clr = '0;
        if (release_ok) begin
            full_clr[rd_ptr] = 1'b1;
        end

        // A SOL on the last column is a short-line restart, not a completion.
        full_set = '0;
        if (state == FILL && bus.in_valid && !sol && last_col) begin
            full_set[wr_ptr] = 1'b1;
        end
    end

    // The completing bank is never the bank being released (it cannot be
    // full while it is being filled), so set and clear never collide.
    // SOL acceptance below tests full[] as it was before this cycle's
    // release, so a freed bank is only reused on a later SOL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            col         <= '0;
            full        <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_ena_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            wr_ena_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            err_short_q <= 1'b0;

            full <= (full & ~full_clr) | full_set;
            if (release_ok) begin
                rd_ptr <= ~rd_ptr;
            end

            if (bus.in_valid) begin
                case (state)
                    IDLE, DROP: begin
                        if (sol) begin
                            if (full[wr_ptr]) begin
                                err_ov_q <= 1'b1;
                                state    <= DROP;
                            end else begin
                                wr_ena_q  <= 1'b1;
                                wr_addr_q <= {wr_ptr, {LOG_N_COLS{1'b0}}};
                                wr_data_q <= bus.in_data;
                                col       <= COL_ONE;
                                state     <= FILL;
                            end
                        end
                    end
                    FILL: begin
                        wr_ena_q  <= 1'b1;
                        wr_data_q <= bus.in_data;
                        if (sol) begin
                            err_short_q <= 1'b1;
                            wr_addr_q   <= {wr_ptr, {LOG_N_COLS{1'b0}}};
                            col         <= COL_ONE;
                        end else begin
                            wr_addr_q <= {wr_ptr, col};
                            if (last_col) begin
                                wr_ptr <= ~wr_ptr;
                                col    <= '0;
                                state  <= IDLE;
                            end else begin
                                col <= col + COL_ONE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.buf_wr_addr  = wr_addr_q;
    assign bus.buf_wr_data  = wr_data_q;
    assign bus.buf_wr_ena   = wr_ena_q;
    assign bus.rd_valid     = full[rd_ptr];
    assign bus.rd_bank      = rd_ptr;
    assign bus.err_overflow = err_ov_q;
    assign bus.err_short    = err_short_q;
endmodule
